// File: rtl/memory_readout_controller.sv
// Read side of the two-bank sample memory: queues drain jobs, streams samples downstream.
// Optional READOUT_HEADER_EN emits a header word (count, bank) ahead of each job.
module memory_readout_controller #(
  parameter int DATA_W     = 8,
  parameter int IDX_W      = 8,
  parameter int BANK_DEPTH = 200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bank0_full,
  input  logic              bank1_full,
  input  logic              memorization_completed,
  input  logic [IDX_W-1:0]  idx_final,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              out_ready,
  output logic [IDX_W:0]    rd_addr,
  output logic              re,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              out_eof,
  output logic              out_hdr,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W = IDX_W + 1;

`ifdef READOUT_HEADER_EN
  typedef enum logic [2:0] {IDLE, HDR, READ, WAIT, OUT} state_t;
`else
  typedef enum logic [1:0] {IDLE, READ, WAIT, OUT} state_t;
`endif

  state_t           state;
  logic [1:0]       q_bank;
  logic [1:0]       q_eof;
  logic [CNT_W-1:0] q_count [2];
  logic [1:0]       q_cnt;
  logic             wr_bank_track;

  logic             cur_bank;
  logic             cur_eof;
  logic [CNT_W-1:0] cur_count;
  logic [CNT_W-1:0] idx;

  logic [1:0]       n_bank;
  logic [1:0]       n_eof;
  logic [CNT_W-1:0] n_count [2];
  logic [1:0]       n_cnt;
  logic             n_track;
  logic             n_ovr;
  logic             pop;
  logic             push_v;
  logic             push_bank;
  logic [CNT_W-1:0] push_count;

  logic             is_last;
  logic [CNT_W-1:0] idx_next;

  assign pop      = (state == IDLE) && (q_cnt != 2'd0);
  assign is_last  = (idx == cur_count - CNT_W'(1));
  assign idx_next = idx + CNT_W'(1);
  assign busy     = (state != IDLE) || (q_cnt != 2'd0);

  // Pop first, then the pulses in order bank0, bank1, completion; a completion
  // in the same cycle as a full pulse lands in the bank the writer just flipped to.
  always_comb begin
    n_bank     = q_bank;
    n_eof      = q_eof;
    n_count    = q_count;
    n_cnt      = q_cnt;
    n_track    = wr_bank_track;
    n_ovr      = 1'b0;
    push_v     = 1'b0;
    push_bank  = 1'b0;
    push_count = '0;
    if (pop) begin
      n_bank[0]  = q_bank[1];
      n_eof[0]   = q_eof[1];
      n_count[0] = q_count[1];
      n_cnt      = q_cnt - 2'd1;
    end
    for (int k = 0; k < 3; k++) begin
      push_v     = (k == 0) ? bank0_full : (k == 1) ? bank1_full : memorization_completed;
      push_bank  = (k == 0) ? 1'b0 : (k == 1) ? 1'b1 : n_track;
      push_count = (k == 2) ? CNT_W'(idx_final) + CNT_W'(1) : CNT_W'(BANK_DEPTH);
      if (push_v) begin
        n_track = ~n_track;
        if (n_cnt == 2'd2) begin
          n_ovr = 1'b1;
        end else begin
          n_bank[n_cnt[0]]  = push_bank;
          n_eof[n_cnt[0]]   = (k == 2);
          n_count[n_cnt[0]] = push_count;
          n_cnt             = n_cnt + 2'd1;
        end
        if ((state != IDLE) && (push_bank == cur_bank))
          n_ovr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_bank        <= '0;
      q_eof         <= '0;
      q_count[0]    <= '0;
      q_count[1]    <= '0;
      q_cnt         <= '0;
      wr_bank_track <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      q_bank        <= n_bank;
      q_eof         <= n_eof;
      q_count       <= n_count;
      q_cnt         <= n_cnt;
      wr_bank_track <= n_track;
      overrun       <= overrun | n_ovr;
    end
  end

`ifdef READOUT_HEADER_EN
  logic [DATA_W-1:0] hdr_word;
  // When the index range fills the data word, the top bit carries the bank instead.
  always_comb begin
    hdr_word = DATA_W'(q_count[0]);
    if (!(DATA_W > IDX_W))
      hdr_word[DATA_W-1] = q_bank[0];
  end
`else
  assign out_hdr = 1'b0;
`endif

  // One sample per READ -> WAIT -> OUT pass; outputs only change on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      re        <= 1'b0;
      rd_addr   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_eof   <= 1'b0;
      cur_bank  <= 1'b0;
      cur_eof   <= 1'b0;
      cur_count <= '0;
      idx       <= '0;
`ifdef READOUT_HEADER_EN
      out_hdr   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            cur_bank  <= q_bank[0];
            cur_eof   <= q_eof[0];
            cur_count <= q_count[0];
            idx       <= '0;
`ifdef READOUT_HEADER_EN
            state     <= HDR;
            out_valid <= 1'b1;
            out_hdr   <= 1'b1;
            out_data  <= hdr_word;
`else
            state     <= READ;
            re        <= 1'b1;
            rd_addr   <= {q_bank[0], IDX_W'(0)};
`endif
          end
        end
`ifdef READOUT_HEADER_EN
        HDR: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_hdr   <= 1'b0;
            re        <= 1'b1;
            rd_addr   <= {cur_bank, idx[IDX_W-1:0]};
            state     <= READ;
          end
        end
`endif
        READ: begin
          re    <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          out_data  <= rd_data;
          out_valid <= 1'b1;
          out_last  <= is_last;
          out_eof   <= is_last & cur_eof;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_eof   <= 1'b0;
            if (is_last) begin
              state <= IDLE;
            end else begin
              idx     <= idx_next;
              re      <= 1'b1;
              rd_addr <= {cur_bank, idx_next[IDX_W-1:0]};
              state   <= READ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_readout_controller.sv
// Scoreboard bench: each job pushes its expected addresses and samples; monitor pops on re / accept.
module tb_memory_readout_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bank0Full = 1'b0;
  logic       bank1Full = 1'b0;
  logic       memCompleted = 1'b0;
  logic [7:0] idxFinal = '0;
  logic [7:0] rdData = '0;
  logic       outReady = 1'b1;
  logic [8:0] rdAddr;
  logic       re;
  logic [7:0] outData;
  logic       outValid, outLast, outEof, outHdr, busy, overrun;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       eof;
  } exp_t;

  exp_t       expQ[$];
  logic [8:0] addrQ[$];
  logic [7:0] memModel [512];

  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;
  bit   randomReady = 1'b0;
  bit   holdPending = 1'b0;
  logic [7:0] heldData = '0;

  memory_readout_controller dut (
    .clk                    (clk),
    .reset                  (reset),
    .bank0_full             (bank0Full),
    .bank1_full             (bank1Full),
    .memorization_completed (memCompleted),
    .idx_final              (idxFinal),
    .rd_data                (rdData),
    .out_ready              (outReady),
    .rd_addr                (rdAddr),
    .re                     (re),
    .out_data               (outData),
    .out_valid              (outValid),
    .out_last               (outLast),
    .out_eof                (outEof),
    .out_hdr                (outHdr),
    .busy                   (busy),
    .overrun                (overrun)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model: data one cycle after re.
  always @(posedge clk) if (re) rdData <= memModel[rdAddr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic pushJob(input logic bank, input int count, input logic eof);
    logic [7:0] i8;
    for (int i = 0; i < count; i++) begin
      i8 = 8'(i);
      addrQ.push_back({bank, i8});
      expQ.push_back('{memModel[{bank, i8}], (i == count - 1), eof && (i == count - 1)});
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (randomReady) outReady = ($urandom_range(0, 99) < 30);
    if (re) begin
      if (addrQ.size() == 0) checkOutput("unexpected_re", 32'(rdAddr), 32'h1ff);
      else checkOutput("rd_addr", 32'(rdAddr), 32'(addrQ.pop_front()));
    end
    if (holdPending) begin
      checkOutput("hold_valid", 32'(outValid), 32'd1);
      checkOutput("hold_data", 32'(outData), 32'(heldData));
    end
    holdPending = 1'b0;
    if (outValid) begin
      if (outReady) begin
        accepted++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_out", 32'(outData), 32'h1ff);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_data", 32'(outData), 32'(e.data));
          checkOutput("out_last", 32'(outLast), 32'(e.last));
          checkOutput("out_eof", 32'(outEof), 32'(e.eof));
          checkOutput("out_hdr", 32'(outHdr), 32'd0);
        end
      end else begin
        holdPending = 1'b1;
        heldData = outData;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // kind: 0 = bank0_full, 1 = bank1_full, 2 = memorization_completed
  task automatic applyStimulus(input int kind, input logic [7:0] fin);
    bank0Full    = (kind == 0);
    bank1Full    = (kind == 1);
    memCompleted = (kind == 2);
    idxFinal     = fin;
    tick();
    bank0Full    = 1'b0;
    bank1Full    = 1'b0;
    memCompleted = 1'b0;
  endtask

  task automatic drain(input string tag, input int maxCyc);
    int n = 0;
    while ((expQ.size() != 0 || busy === 1'b1) && n < maxCyc) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(n < maxCyc), 32'd1);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    expQ.delete();
    addrQ.delete();
    holdPending = 1'b0;
    tick();
  endtask

  initial begin
    for (int a = 0; a < 512; a++) memModel[a] = 8'((a * 37 + 11) ^ (a >> 3));

    // Reset state
    ticks(2);
    checkOutput("rst_valid", 32'(outValid), 32'd0);
    checkOutput("rst_re", 32'(re), 32'd0);
    checkOutput("rst_addr", 32'(rdAddr), 32'd0);
    checkOutput("rst_data", 32'(outData), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_hdr", 32'(outHdr), 32'd0);
    reset = 1'b0;
    tick();

    // Full bank 0 with out_ready held high
    pushJob(1'b0, 200, 1'b0);
    applyStimulus(0, 8'd0);
    drain("t1_drain", 1000);
    checkOutput("t1_busy_low", 32'(busy), 32'd0);
    checkOutput("t1_overrun", 32'(overrun), 32'd0);

    // Bank 1 queued behind bank 0
    resetDut();
    pushJob(1'b0, 200, 1'b0);
    applyStimulus(0, 8'd0);
    ticks(50);
    pushJob(1'b1, 200, 1'b0);
    applyStimulus(1, 8'd0);
    drain("t2_drain", 2000);
    checkOutput("t2_overrun", 32'(overrun), 32'd0);

    // Partial bank after a full bank 0
    resetDut();
    pushJob(1'b0, 200, 1'b0);
    applyStimulus(0, 8'd0);
    ticks(5);
    pushJob(1'b1, 37, 1'b1);
    applyStimulus(2, 8'd36);
    drain("t3_drain", 1500);
    checkOutput("t3_overrun", 32'(overrun), 32'd0);

    // Random backpressure
    resetDut();
    randomReady = 1'b1;
    pushJob(1'b1, 200, 1'b0);
    applyStimulus(1, 8'd0);
    drain("t4_drain", 6000);
    randomReady = 1'b0;
    outReady = 1'b1;

    // Three full pulses during one readout: third dropped
    resetDut();
    pushJob(1'b0, 200, 1'b0);
    applyStimulus(0, 8'd0);
    ticks(10);
    pushJob(1'b1, 200, 1'b0);
    applyStimulus(1, 8'd0);
    ticks(3);
    pushJob(1'b0, 200, 1'b0);
    applyStimulus(0, 8'd0);
    ticks(3);
    applyStimulus(1, 8'd0);
    tick();
    checkOutput("t5_overrun_set", 32'(overrun), 32'd1);
    drain("t5_drain", 3000);
    checkOutput("t5_overrun_sticky", 32'(overrun), 32'd1);

    // Reset mid-readout, then a fresh bank 1
    resetDut();
    accepted = 0;
    pushJob(1'b0, 200, 1'b0);
    applyStimulus(0, 8'd0);
    begin
      int n = 0;
      while (accepted < 100 && n < 1000) begin
        tick();
        n++;
      end
      checkOutput("t6_reach100", 32'(n < 1000), 32'd1);
    end
    reset = 1'b1;
    expQ.delete();
    addrQ.delete();
    holdPending = 1'b0;
    tick();
    checkOutput("t6_valid", 32'(outValid), 32'd0);
    checkOutput("t6_re", 32'(re), 32'd0);
    checkOutput("t6_data", 32'(outData), 32'd0);
    checkOutput("t6_last", 32'(outLast), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    tick();
    pushJob(1'b1, 200, 1'b0);
    applyStimulus(1, 8'd0);
    drain("t6_drain", 1000);
    checkOutput("t6_overrun_end", 32'(overrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_readout_controller.md
Name: memory_readout_controller

Overview:
- Read side of the two-bank sample memory: drains each bank after the write-side controller reports it full, or after it reports memorization_completed for a partial bank.
- Streams samples to the downstream spectrogram/output stage over a valid/ready handshake.
- Tracks bank order and flags overrun when the writer refills a bank before it has been drained.

Parameters:
- DATA_W, 8, sample width of memory read data and out_data.
- IDX_W, 8, index width within one bank; memory address is {bank, idx}, i.e. IDX_W+1 bits.
- BANK_DEPTH, 200, samples per full bank; last full index = BANK_DEPTH-1.

Ports:
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- bank0_full  in  1  1-cycle pulse: bank 0 holds BANK_DEPTH valid samples.
- bank1_full  in  1  1-cycle pulse: bank 1 holds BANK_DEPTH valid samples.
- memorization_completed  in  1  1-cycle pulse: capture ended; current write bank is partial.
- idx_final  in  IDX_W  last written index of the partial bank; sampled on memorization_completed.
- rd_data  in  DATA_W  memory read data; synchronous RAM, valid 1 cycle after re.
- out_ready  in  1  downstream accepts out_data.
- rd_addr  out  IDX_W+1  read address: bit IDX_W = bank, low bits = index.
- re  out  1  memory read enable.
- out_data  out  DATA_W  sample (or header) to downstream.
- out_valid  out  1  out_data valid.
- out_last  out  1  with out_valid: last sample of the current bank readout.
- out_eof  out  1  with out_valid: last sample of a capture (partial bank).
- out_hdr  out  1  with out_valid: word is a header (see optional feature).
- busy  out  1  readout in progress or job queued.
- overrun  out  1  sticky; cleared only by reset.

Behaviour:
- Reset values: all outputs 0. Job queue empty; wr_bank_track = 0; FSM in IDLE.
- Clock/reset: clk; reset asynchronous, active-high.
- Write-bank tracking: wr_bank_track toggles on each bank0_full, bank1_full or memorization_completed pulse, mirroring the writer's bank flip.
- Job creation:
  - bankN_full pushes job {bank=N, count=BANK_DEPTH, eof=0}.
  - memorization_completed pushes job {bank=wr_bank_track (before toggle), count=idx_final+1, eof=1}.
  - Count width IDX_W+1, so 256 is representable.
- Queue: 2-entry FIFO, jobs served oldest first.
  - Simultaneous full pulse and completion pulse: push the full job first.
  - Push while 2 entries are held: job dropped, overrun=1.
  - Push naming the bank currently being read: job still queued, overrun=1.
- FSM:
  - IDLE: if queue non-empty, pop a job, idx=0 -> READ (HDR when the feature is enabled).
  - READ: re=1, rd_addr={bank,idx} for exactly 1 cycle -> WAIT.
  - WAIT: capture rd_data into the out register -> OUT.
  - OUT: out_valid=1, data held stable until out_ready. out_last=1 when idx==count-1; out_eof=out_last&eof. On the accepting cycle (out_valid&out_ready): if idx==count-1 -> IDLE, else idx+1 -> READ.
- Throughput: one sample per 3 cycles minimum. out_valid never depends combinationally on out_ready. out_valid is never withdrawn before acceptance.
- busy = (state!=IDLE) | queue non-empty.
- Reset mid-readout: abort immediately, queue cleared, out_valid=0.

Optional Feature:
- Macro READOUT_HEADER_EN.
- Defined: state HDR precedes READ for each job. It presents out_valid=1, out_hdr=1, out_data = count[DATA_W-1:0] (count mod 2^DATA_W), and bit DATA_W-1 replaced by the bank number when DATA_W>IDX_W is false. It is held until out_ready, then -> READ.
- Undefined: HDR state absent; out_hdr tied 0.

Test Plan:
- bank0_full pulse, out_ready=1 -> rd_addr 0x000..0x0C7 in order; 200 outputs equal to preloaded RAM; out_last only on the 200th; out_eof=0; busy falls after the last.
- bank0_full, then bank1_full 50 cycles later -> bank 0 fully drained before the first rd_addr 0x100; no overrun.
- After bank0_full, memorization_completed with idx_final=36 -> 37 samples from rd_addr 0x100..0x124; the last has out_last=1 and out_eof=1.
- out_ready toggled with a random 30% duty -> out_data stable while out_valid&!out_ready; no sample lost or duplicated over 200 words.
- Three full pulses during one readout -> third job dropped; overrun=1 and stays 1 until reset.
- Assert reset during sample 100 of a bank -> all outputs 0 next cycle; a fresh bank1_full afterwards starts at rd_addr 0x100. With READOUT_HEADER_EN, each job emits out_hdr=1 with count (200 -> 0xC8) first.
